// File: rtl/key_pulse_gen_pkg.sv
// Shared types and default timing for the pushbutton conditioner.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  localparam int DEBOUNCE_20MS_AT_50MHZ = 1000000;
  localparam int REPEAT_DELAY_DEF       = 25000000;
  localparam int REPEAT_PERIOD_DEF      = 5000000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_pulse_gen_sync_chain.sv
// Multi-flop synchroniser for a single asynchronous input; async active-low reset
// presets every stage to RST_VAL.
module sync_chain #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= {STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/key_pulse_gen.sv
// Synchronise, debounce and edge-detect one active-low pushbutton into a press strobe
// and a held level. Define KEY_PULSE_GEN_AUTOREPEAT_EN to add hold-to-repeat strobes.
module key_pulse_gen
  import key_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_AT_50MHZ,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_key_n,
  output logic o_pressed,
  output logic o_pulse
);

  localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DEB_C = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic       w_key_sync;
  logic       w_k_s;
  key_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic       r_pulse, w_pulse_nxt;
  logic       r_pressed, w_pressed_nxt;
  logic       w_rep_fire;

  sync_chain #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (i_key_n),
    .o_q     (w_key_sync)
  );

  assign w_k_s     = ~w_key_sync;
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + ONE_C;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pulse   <= 1'b0;
      r_pressed <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pulse   <= w_pulse_nxt;
      r_pressed <= w_pressed_nxt;
    end
  end

  // state        | meaning
  // IDLE         | key accepted as released
  // PRESS_WAIT   | key reads pressed, counting stable cycles
  // HELD         | key accepted as pressed
  // RELEASE_WAIT | key reads released, counting stable cycles
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_k_s) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = ONE_C;
        end
      end
      PRESS_WAIT: begin
        if (!w_k_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DEB_C) begin
          w_state_nxt = HELD;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      HELD: begin
        if (!w_k_s) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = ONE_C;
        end
      end
      RELEASE_WAIT: begin
        if (w_k_s) begin
          w_state_nxt = HELD;
        end else if (r_cnt == DEB_C) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef KEY_PULSE_GEN_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_DLY_C = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] REP_PER_C = CW'(REPEAT_PERIOD);

  logic [CW-1:0] r_rep_cnt;
  logic          r_rep_phase;

  assign w_rep_fire = (r_state == HELD) && (w_state_nxt == HELD) &&
                      (r_rep_cnt == (r_rep_phase ? REP_PER_C : REP_DLY_C));

  // Hold time stops counting while a release is being qualified; the delay/period
  // phase survives a glitch so a bouncing release never re-arms the long delay.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rep_cnt   <= '0;
      r_rep_phase <= 1'b0;
    end else if (w_state_nxt == HELD && r_state != HELD) begin
      r_rep_cnt <= ONE_C;
      if (r_state == PRESS_WAIT) r_rep_phase <= 1'b0;
    end else if (w_rep_fire) begin
      r_rep_cnt   <= ONE_C;
      r_rep_phase <= 1'b1;
    end else if (r_state == HELD && r_rep_cnt != '1) begin
      r_rep_cnt <= r_rep_cnt + ONE_C;
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  always_comb begin
    w_pulse_nxt   = ~r_pulse &
                    (((r_state == PRESS_WAIT) && (w_state_nxt == HELD)) | w_rep_fire);
    w_pressed_nxt = (r_state == HELD) |
                    ((r_state == RELEASE_WAIT) && (w_state_nxt != IDLE));
  end

  assign o_pulse   = r_pulse;
  assign o_pressed = r_pressed;

endmodule

// File: doc/key_pulse_gen.md
Name: key_pulse_gen

Overview:
- Conditions one raw, active-low DE1 pushbutton (KEY[n]) into clean signals for the guessing-game core.
- Synchronises the raw input, debounces it, and emits exactly one single-cycle pulse per physical press.
- Sits directly upstream of the game core's i_enter input and replaces the bare inversion currently in the top level.
- Also provides a debounced level output for LED or status use.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the input synchroniser chain (minimum 2).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (20 ms at 50 MHz); must be >= 1.
- REPEAT_DELAY, 25000000, cycles held before the first auto-repeat pulse (used only with the optional feature).
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses (used only with the optional feature).

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset_n  in  1  asynchronous, active-low reset.
- i_key_n  in  1  raw pushbutton, active-low, asynchronous to clk.
- o_pressed  out  1  debounced level: 1 while the key is accepted as held.
- o_pulse  out  1  one-cycle strobe on each accepted press (and on repeats when enabled).

Behaviour:
- Reset:
  - Assertion of reset_n is asynchronous; deassertion is used synchronously.
  - During reset the synchroniser presets to the released value (1), all counters clear, state = IDLE, o_pressed = 0, o_pulse = 0.
- Synchroniser:
  - i_key_n passes through SYNC_STAGES flops, then is inverted internally to an active-high signal k_s.
  - Latency from input edge to k_s is SYNC_STAGES cycles.
- Counter: width $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1); saturates and never wraps.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
- IDLE:
  - k_s = 1 -> PRESS_WAIT, counter = 1.
  - Otherwise stay.
- PRESS_WAIT:
  - k_s = 0 -> IDLE; this is a bounce and no pulse is produced.
  - k_s = 1 and counter == DEBOUNCE_CYCLES -> HELD; o_pulse = 1 for that single cycle, o_pressed = 1 from the next cycle.
  - Otherwise counter increments.
- HELD:
  - k_s = 0 -> RELEASE_WAIT, counter = 1.
  - o_pressed stays 1.
- RELEASE_WAIT:
  - k_s = 1 -> HELD; glitch ignored, no pulse.
  - k_s = 0 and counter == DEBOUNCE_CYCLES -> IDLE, o_pressed = 0.
  - Otherwise counter increments.
- Latency:
  - Press: first o_pulse occurs SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles after a clean falling edge on i_key_n.
  - Release: o_pressed falls SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles after a clean rising edge.
- Pulse rules:
  - o_pulse is registered and never high for two consecutive cycles.
  - No pulse on release.
  - No pulse on reset deassertion, even if the key is held; a held key re-qualifies through PRESS_WAIT and then pulses once.
- Reset mid-operation: any state returns to IDLE immediately and a pending pulse is discarded.
- DEBOUNCE_CYCLES = 1: the press is accepted on the cycle after k_s first reads 1.

Optional Feature:
- Macro: KEY_PULSE_GEN_AUTOREPEAT_EN.
- Defined:
  - In HELD, the counter tracks hold time.
  - After REPEAT_DELAY cycles in HELD, o_pulse fires once, then again every REPEAT_PERIOD cycles while held.
  - The repeat counter resets on entry to HELD, including on return from RELEASE_WAIT.
  - A glitch in RELEASE_WAIT freezes repeat timing but does not restart the delay.
- Undefined: exactly one pulse per press; REPEAT_DELAY and REPEAT_PERIOD are unused, and no repeat logic is synthesised.

Decomposition:
- Package key_pkg:
  - FSM state enum (key_state_t: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT).
  - Default timing constants: DEBOUNCE_20MS_AT_50MHZ = 1000000, REPEAT_DELAY_DEF, REPEAT_PERIOD_DEF.
- One natural sub-module: sync_chain, a parameterised SYNC_STAGES flop chain with async active-low reset and a reset value parameter. It is reusable for SW inputs feeding i_guess.
- The FSM, counter and pulse register stay in key_pulse_gen.

Test Plan:
- All tests use SYNC_STAGES=2 and DEBOUNCE_CYCLES=8.
- Clean press: i_key_n 1->0 held 20 cycles -> one o_pulse exactly 11 cycles after the edge; o_pressed = 1 from cycle 12.
- Bounce: i_key_n toggles low for 3 cycles, high for 2, low for 4, then high -> no o_pulse; o_pressed stays 0.
- Release glitch: held key goes high for 3 cycles, then low -> o_pressed stays 1, no second pulse; a clean release of 20 cycles drops o_pressed 11 cycles after the edge.
- Reset mid-press: reset_n = 0 during PRESS_WAIT at counter = 5 with the key still held -> outputs 0 immediately; after release of reset, one pulse 11 cycles later and none at the reset edge.
- Held across reset: key low throughout, reset_n pulsed -> exactly one o_pulse after re-qualification.
- Auto-repeat (macro defined, REPEAT_DELAY=16, REPEAT_PERIOD=4), key held 40 cycles -> pulses at the initial acceptance, +16, then every 4 cycles; no pulse after release.
